// File: rtl/div_sequencer.sv
// Sequencer between the execution unit and the divider for x86 DIV/IDIV.
// Latches and extends the operands, launches the divider, guards it with a watchdog, and registers write-back.
module div_sequencer #(
   parameter int TIMEOUT = 31
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        is_8_bit,
   input  logic        is_signed,
   input  logic [15:0] ax_in,
   input  logic [15:0] dx_in,
   input  logic [15:0] operand,
   output logic        ready,
   output logic        div_start,
   output logic        div_is_8_bit,
   output logic        div_is_signed,
   output logic [31:0] div_dividend,
   output logic [15:0] div_divisor,
   input  logic        div_complete,
   input  logic        div_error,
   input  logic [15:0] div_quotient,
   input  logic [15:0] div_remainder,
   output logic        done,
   output logic [15:0] ax_out,
   output logic [15:0] dx_out,
   output logic        ax_wr,
   output logic        dx_wr,
   output logic        divide_error,
   output logic        timeout
);

   localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_WRITEBACK
   } state_t;

   state_t          r_state;
   logic [WD_W-1:0] r_wd;

   logic        r_ready;
   logic        r_div_start;
   logic        r_div_is_8_bit;
   logic        r_div_is_signed;
   logic [31:0] r_div_dividend;
   logic [15:0] r_div_divisor;
   logic        r_done;
   logic [15:0] r_ax_out;
   logic [15:0] r_dx_out;
   logic        r_ax_wr;
   logic        r_dx_wr;
   logic        r_divide_error;
   logic        r_timeout;

   logic [15:0] w_dividend_hi;
   logic [7:0]  w_divisor_hi;
   logic [31:0] w_ext_dividend;
   logic [15:0] w_ext_divisor;
   logic        w_ax_sign;
   logic        w_op_sign;

   // In the 8-bit forms the high halves are pure sign (IDIV) or zero (DIV) fill.
   assign w_ax_sign = is_signed & ax_in[15];
   assign w_op_sign = is_signed & operand[7];

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_dividend_hi
         assign w_dividend_hi[gi] = is_8_bit ? w_ax_sign : dx_in[gi];
      end
      for (genvar gi = 0; gi < 8; gi++) begin : g_divisor_hi
         assign w_divisor_hi[gi] = is_8_bit ? w_op_sign : operand[8+gi];
      end
   endgenerate

   assign w_ext_dividend = {w_dividend_hi, ax_in};
   assign w_ext_divisor  = {w_divisor_hi, operand[7:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= S_IDLE;
         r_wd            <= '0;
         r_ready         <= 1'b1;
         r_div_start     <= 1'b0;
         r_div_is_8_bit  <= 1'b0;
         r_div_is_signed <= 1'b0;
         r_div_dividend  <= '0;
         r_div_divisor   <= '0;
         r_done          <= 1'b0;
         r_ax_out        <= '0;
         r_dx_out        <= '0;
         r_ax_wr         <= 1'b0;
         r_dx_wr         <= 1'b0;
         r_divide_error  <= 1'b0;
         r_timeout       <= 1'b0;
      end else begin
         r_div_start <= 1'b0;
         r_done      <= 1'b0;
         r_ax_wr     <= 1'b0;
         r_dx_wr     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req) begin
                  r_div_is_8_bit  <= is_8_bit;
                  r_div_is_signed <= is_signed;
                  r_div_dividend  <= w_ext_dividend;
                  r_div_divisor   <= w_ext_divisor;
                  r_div_start     <= 1'b1;
                  r_ready         <= 1'b0;
                  r_state         <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               r_wd    <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               // Results are registered straight into the write-back outputs so done carries them.
               if (div_complete) begin
                  r_state <= S_WRITEBACK;
                  r_done  <= 1'b1;
                  r_timeout <= 1'b0;
                  if (div_error) begin
                     r_divide_error <= 1'b1;
                  end else if (r_div_is_8_bit) begin
                     r_divide_error <= 1'b0;
                     r_ax_out       <= {div_remainder[7:0], div_quotient[7:0]};
                     r_ax_wr        <= 1'b1;
                  end else begin
                     r_divide_error <= 1'b0;
                     r_ax_out       <= div_quotient;
                     r_dx_out       <= div_remainder;
                     r_ax_wr        <= 1'b1;
                     r_dx_wr        <= 1'b1;
                  end
               end else if (r_wd == WD_LIMIT) begin
                  r_state        <= S_WRITEBACK;
                  r_done         <= 1'b1;
                  r_divide_error <= 1'b1;
                  r_timeout      <= 1'b1;
               end else begin
                  r_wd <= r_wd + 1'b1;
               end
            end
            S_WRITEBACK: begin
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ready         = r_ready;
   assign div_start     = r_div_start;
   assign div_is_8_bit  = r_div_is_8_bit;
   assign div_is_signed = r_div_is_signed;
   assign div_dividend  = r_div_dividend;
   assign div_divisor   = r_div_divisor;
   assign done          = r_done;
   assign ax_out        = r_ax_out;
   assign dx_out        = r_dx_out;
   assign ax_wr         = r_ax_wr;
   assign dx_wr         = r_dx_wr;
   assign divide_error  = r_divide_error;
   assign timeout       = r_timeout;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer; the bench plays the divider with hand-computed results.
module tb_div_sequencer;

   localparam int TO = 31;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0;
   logic        is_8_bit = 1'b0;
   logic        is_signed = 1'b0;
   logic [15:0] ax_in = '0;
   logic [15:0] dx_in = '0;
   logic [15:0] operand = '0;
   logic        ready;
   logic        div_start;
   logic        div_is_8_bit;
   logic        div_is_signed;
   logic [31:0] div_dividend;
   logic [15:0] div_divisor;
   logic        div_complete = 1'b0;
   logic        div_error = 1'b0;
   logic [15:0] div_quotient = '0;
   logic [15:0] div_remainder = '0;
   logic        done;
   logic [15:0] ax_out;
   logic [15:0] dx_out;
   logic        ax_wr;
   logic        dx_wr;
   logic        divide_error;
   logic        timeout;

   int n_tests = 0;
   int n_fail  = 0;

   div_sequencer #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .req(req), .is_8_bit(is_8_bit), .is_signed(is_signed),
      .ax_in(ax_in), .dx_in(dx_in), .operand(operand), .ready(ready), .div_start(div_start),
      .div_is_8_bit(div_is_8_bit), .div_is_signed(div_is_signed), .div_dividend(div_dividend),
      .div_divisor(div_divisor), .div_complete(div_complete), .div_error(div_error),
      .div_quotient(div_quotient), .div_remainder(div_remainder), .done(done), .ax_out(ax_out),
      .dx_out(dx_out), .ax_wr(ax_wr), .dx_wr(dx_wr), .divide_error(divide_error), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one edge, then scramble the inputs so the latched copies are what count.
   task automatic issue(input logic b8, input logic sg, input logic [15:0] ax, input logic [15:0] dx,
                        input logic [15:0] op);
      is_8_bit = b8; is_signed = sg; ax_in = ax; dx_in = dx; operand = op; req = 1'b1;
      tick();
      req = 1'b0; ax_in = 16'hDEAD; dx_in = 16'hBEEF; operand = 16'h5A5A;
      is_8_bit = ~b8; is_signed = ~sg;
   endtask

   // From LAUNCH: enter WAIT, idle n more WAIT cycles, then complete; returns in the WRITEBACK cycle.
   task automatic finish_wait(input int n, input logic err, input logic [15:0] q, input logic [15:0] r);
      tick();
      repeat (n) tick();
      div_complete = 1'b1; div_error = err; div_quotient = q; div_remainder = r;
      tick();
      div_complete = 1'b0; div_error = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
      n_tests++; if (div_start !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: start %b done %b want 0 0", div_start, done); end
      n_tests++; if (ax_out !== 16'h0 || dx_out !== 16'h0) begin n_fail++; $display("FAIL reset_axdx: got %h %h want 0000 0000", ax_out, dx_out); end
      n_tests++; if (div_dividend !== 32'h0 || div_divisor !== 16'h0) begin n_fail++; $display("FAIL reset_operands: got %h %h want 0", div_dividend, div_divisor); end
      n_tests++; if (divide_error !== 1'b0 || timeout !== 1'b0 || ax_wr !== 1'b0 || dx_wr !== 1'b0) begin n_fail++; $display("FAIL reset_flags: err %b to %b axwr %b dxwr %b want 0", divide_error, timeout, ax_wr, dx_wr); end
   endtask

   task automatic test_div16();
      // 100000 / 7 = 14285 r 5
      issue(1'b0, 1'b0, 16'h86A0, 16'h0001, 16'h0007);
      n_tests++; if (div_start !== 1'b1 || ready !== 1'b0) begin n_fail++; $display("FAIL div16_launch: start %b ready %b want 1 0", div_start, ready); end
      n_tests++; if (div_dividend !== 32'h0001_86A0 || div_divisor !== 16'h0007) begin n_fail++; $display("FAIL div16_operands: got %h %h want 000186a0 0007", div_dividend, div_divisor); end
      n_tests++; if (div_is_8_bit !== 1'b0 || div_is_signed !== 1'b0) begin n_fail++; $display("FAIL div16_mode: got %b %b want 0 0", div_is_8_bit, div_is_signed); end
      finish_wait(18, 1'b0, 16'h37CD, 16'h0005);
      n_tests++; if (done !== 1'b1 || ax_wr !== 1'b1 || dx_wr !== 1'b1 || divide_error !== 1'b0) begin n_fail++; $display("FAIL div16_done: done %b axwr %b dxwr %b err %b want 1 1 1 0", done, ax_wr, dx_wr, divide_error); end
      n_tests++; if (ax_out !== 16'h37CD || dx_out !== 16'h0005) begin n_fail++; $display("FAIL div16_result: got %h %h want 37cd 0005", ax_out, dx_out); end
      n_tests++; if (div_dividend !== 32'h0001_86A0 || div_divisor !== 16'h0007) begin n_fail++; $display("FAIL div16_hold: got %h %h want 000186a0 0007", div_dividend, div_divisor); end
      tick();
      n_tests++; if (done !== 1'b0 || ax_wr !== 1'b0 || dx_wr !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL div16_idle: done %b axwr %b dxwr %b ready %b want 0 0 0 1", done, ax_wr, dx_wr, ready); end
      n_tests++; if (ax_out !== 16'h37CD || dx_out !== 16'h0005) begin n_fail++; $display("FAIL div16_keep: got %h %h want 37cd 0005", ax_out, dx_out); end
   endtask

   task automatic test_idiv8();
      // -100 / 7 = -14 r -2 -> AX = {FE, F2}
      issue(1'b1, 1'b1, 16'hFF9C, 16'h1234, 16'h0007);
      n_tests++; if (div_dividend !== 32'hFFFF_FF9C || div_divisor !== 16'h0007) begin n_fail++; $display("FAIL idiv8_operands: got %h %h want ffffff9c 0007", div_dividend, div_divisor); end
      n_tests++; if (div_is_8_bit !== 1'b1 || div_is_signed !== 1'b1) begin n_fail++; $display("FAIL idiv8_mode: got %b %b want 1 1", div_is_8_bit, div_is_signed); end
      finish_wait(10, 1'b0, 16'hFFF2, 16'hFFFE);
      n_tests++; if (done !== 1'b1 || ax_wr !== 1'b1 || dx_wr !== 1'b0) begin n_fail++; $display("FAIL idiv8_done: done %b axwr %b dxwr %b want 1 1 0", done, ax_wr, dx_wr); end
      n_tests++; if (ax_out !== 16'hFEF2 || dx_out !== 16'h0005) begin n_fail++; $display("FAIL idiv8_result: got %h %h want fef2 0005", ax_out, dx_out); end
      tick();
      // 100 / -123 = 0 r 100; operand high byte must be ignored
      issue(1'b1, 1'b1, 16'h0064, 16'h0000, 16'hAB85);
      n_tests++; if (div_dividend !== 32'h0000_0064 || div_divisor !== 16'hFF85) begin n_fail++; $display("FAIL idiv8_negdiv: got %h %h want 00000064 ff85", div_dividend, div_divisor); end
      finish_wait(4, 1'b0, 16'h0000, 16'h0064);
      n_tests++; if (done !== 1'b1 || ax_out !== 16'h6400) begin n_fail++; $display("FAIL idiv8_negdiv_result: done %b ax %h want 1 6400", done, ax_out); end
      tick();
   endtask

   task automatic test_errors();
      // DIV8 65436 / 133 overflows 8 bits; checks zero extension with operand[7] set
      issue(1'b1, 1'b0, 16'hFF9C, 16'h7777, 16'hFF85);
      n_tests++; if (div_dividend !== 32'h0000_FF9C || div_divisor !== 16'h0085) begin n_fail++; $display("FAIL div8_operands: got %h %h want 0000ff9c 0085", div_dividend, div_divisor); end
      finish_wait(0, 1'b1, 16'h1111, 16'h2222);
      n_tests++; if (done !== 1'b1 || divide_error !== 1'b1 || timeout !== 1'b0) begin n_fail++; $display("FAIL div8_ovf_flags: done %b err %b to %b want 1 1 0", done, divide_error, timeout); end
      n_tests++; if (ax_wr !== 1'b0 || dx_wr !== 1'b0 || ax_out !== 16'h6400 || dx_out !== 16'h0005) begin n_fail++; $display("FAIL div8_ovf_nowrite: axwr %b dxwr %b ax %h dx %h want 0 0 6400 0005", ax_wr, dx_wr, ax_out, dx_out); end
      tick();
      n_tests++; if (divide_error !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL div8_ovf_hold: err %b done %b want 1 0", divide_error, done); end
      // DIV16 by zero
      issue(1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000);
      n_tests++; if (div_divisor !== 16'h0000 || div_dividend !== 32'h0000_0010) begin n_fail++; $display("FAIL div0_operands: got %h %h want 00000010 0000", div_dividend, div_divisor); end
      finish_wait(0, 1'b1, 16'hFFFF, 16'hFFFF);
      n_tests++; if (done !== 1'b1 || divide_error !== 1'b1 || ax_wr !== 1'b0 || dx_wr !== 1'b0 || ax_out !== 16'h6400 || dx_out !== 16'h0005) begin n_fail++; $display("FAIL div0_response: done %b err %b axwr %b dxwr %b ax %h dx %h want 1 1 0 0 6400 0005", done, divide_error, ax_wr, dx_wr, ax_out, dx_out); end
      tick();
   endtask

   task automatic test_timeout();
      int k;
      issue(1'b0, 1'b1, 16'h1234, 16'h0000, 16'h0003);
      k = 0;
      while (done !== 1'b1 && k < TO + 10) begin
         tick();
         k++;
      end
      n_tests++; if (k !== TO + 2) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles want %0d", k, TO + 2); end
      n_tests++; if (divide_error !== 1'b1 || timeout !== 1'b1 || ax_wr !== 1'b0 || dx_wr !== 1'b0) begin n_fail++; $display("FAIL timeout_flags: err %b to %b axwr %b dxwr %b want 1 1 0 0", divide_error, timeout, ax_wr, dx_wr); end
      tick();
      div_complete = 1'b1; div_quotient = 16'h9999;
      tick();
      div_complete = 1'b0;
      n_tests++; if (done !== 1'b0 || ready !== 1'b1 || div_start !== 1'b0 || ax_out !== 16'h6400) begin n_fail++; $display("FAIL timeout_late_complete: done %b ready %b start %b ax %h want 0 1 0 6400", done, ready, div_start, ax_out); end
   endtask

   task automatic test_collision();
      // Completion on the very cycle the watchdog hits its limit must be a success
      issue(1'b0, 1'b0, 16'h0064, 16'h0000, 16'h000A);
      finish_wait(TO, 1'b0, 16'h000A, 16'h0000);
      n_tests++; if (done !== 1'b1 || divide_error !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL collision_flags: done %b err %b to %b want 1 0 0", done, divide_error, timeout); end
      n_tests++; if (ax_out !== 16'h000A || dx_out !== 16'h0000 || ax_wr !== 1'b1 || dx_wr !== 1'b1) begin n_fail++; $display("FAIL collision_result: ax %h dx %h axwr %b dxwr %b want 000a 0000 1 1", ax_out, dx_out, ax_wr, dx_wr); end
      tick();
   endtask

   task automatic test_back_to_back();
      int extra;
      issue(1'b0, 1'b0, 16'h4444, 16'h0002, 16'h0009);
      tick(); tick(); tick();
      reset = 1'b1; req = 1'b1;
      is_8_bit = 1'b0; is_signed = 1'b0; ax_in = 16'h1000; dx_in = 16'h0000; operand = 16'h0010;
      tick();
      reset = 1'b0;
      n_tests++; if (ready !== 1'b1 || div_start !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midreset_ctrl: ready %b start %b done %b want 1 0 0", ready, div_start, done); end
      n_tests++; if (ax_out !== 16'h0 || dx_out !== 16'h0 || div_dividend !== 32'h0 || div_divisor !== 16'h0 || divide_error !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL midreset_zero: ax %h dx %h dvd %h dvs %h err %b to %b want 0", ax_out, dx_out, div_dividend, div_divisor, divide_error, timeout); end
      tick();
      n_tests++; if (div_start !== 1'b1 || div_dividend !== 32'h0000_1000 || div_divisor !== 16'h0010) begin n_fail++; $display("FAIL held_req_launch: start %b dvd %h dvs %h want 1 00001000 0010", div_start, div_dividend, div_divisor); end
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (div_start === 1'b1) extra++;
      end
      div_complete = 1'b1; div_quotient = 16'h0100; div_remainder = 16'h0000;
      tick();
      div_complete = 1'b0;
      if (div_start === 1'b1) extra++;
      n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL busy_req_ignored: got %0d extra starts want 0", extra); end
      n_tests++; if (done !== 1'b1 || ax_out !== 16'h0100 || dx_out !== 16'h0000) begin n_fail++; $display("FAIL held_req_result: done %b ax %h dx %h want 1 0100 0000", done, ax_out, dx_out); end
      // 80 / -5 = -16 r 0, issued the first cycle ready returns
      is_8_bit = 1'b1; is_signed = 1'b1; ax_in = 16'h0050; operand = 16'h00FB;
      tick();
      n_tests++; if (ready !== 1'b1 || done !== 1'b0 || div_start !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: ready %b done %b start %b want 1 0 0", ready, done, div_start); end
      tick();
      req = 1'b0;
      n_tests++; if (div_start !== 1'b1 || div_dividend !== 32'h0000_0050 || div_divisor !== 16'hFFFB) begin n_fail++; $display("FAIL b2b_launch: start %b dvd %h dvs %h want 1 00000050 fffb", div_start, div_dividend, div_divisor); end
      finish_wait(8, 1'b0, 16'hFFF0, 16'h0000);
      n_tests++; if (done !== 1'b1 || ax_out !== 16'h00F0 || ax_wr !== 1'b1 || dx_wr !== 1'b0 || dx_out !== 16'h0000) begin n_fail++; $display("FAIL b2b_result: done %b ax %h axwr %b dxwr %b dx %h want 1 00f0 1 0 0000", done, ax_out, ax_wr, dx_wr, dx_out); end
      tick();
   endtask

   initial begin
      test_reset();
      test_div16();
      test_idiv8();
      test_errors();
      test_timeout();
      test_collision();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1, "time limit");
   end

endmodule
